// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample ticks with a fractional period,
// plus midpoint and bit-end strobes. Divisor changes take effect at period boundaries.
module baud_gen_frac #(
    parameter int DIV_W   = 16,
    parameter int FRAC_W  = 4,
    parameter int OSR     = 16,
    parameter int DEF_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              div_err
);

    localparam int OSC_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [OSC_W-1:0] OS_LAST = OSC_W'(OSR - 1);
    localparam logic [OSC_W-1:0] OS_MID  = OSC_W'(OSR / 2 - 1);
    localparam logic [DIV_W-1:0] DEF_INT = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] MIN_INT = DIV_W'(2);

    logic [DIV_W-1:0]  sh_int_q,   sh_int_d;
    logic [FRAC_W-1:0] sh_frac_q,  sh_frac_d;
    logic [DIV_W-1:0]  act_int_q,  act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W:0]    cnt_q,      cnt_d;
    logic [OSC_W-1:0]  os_cnt_q,   os_cnt_d;
    logic [FRAC_W-1:0] acc_q,      acc_d;
    logic              carry_q,    carry_d;
    logic              os_tick_q,  os_tick_d;
    logic              mid_tick_q, mid_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              div_err_q,  div_err_d;

    logic [DIV_W:0]    len;
    logic [DIV_W:0]    len_m1;
    logic              at_end;
    logic [FRAC_W:0]   frac_sum;
    logic [OSC_W-1:0]  os_cnt_nxt;

    assign len        = {1'b0, act_int_q} + {{DIV_W{1'b0}}, carry_q};
    assign len_m1     = len - (DIV_W+1)'(1);
    // >= rather than == so a divisor shrunk while paused cannot strand cnt past the end
    assign at_end     = (cnt_q >= len_m1);
    assign frac_sum   = {1'b0, acc_q} + {1'b0, act_frac_q};
    assign os_cnt_nxt = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OSC_W'(1);

    always_comb begin
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        cnt_d      = cnt_q;
        os_cnt_d   = os_cnt_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        div_err_d  = div_err_q;
        os_tick_d  = 1'b0;
        mid_tick_d = 1'b0;
        bit_tick_d = 1'b0;

        if (div_load) begin
            if (div_int < MIN_INT) begin
                sh_int_d  = MIN_INT;
                sh_frac_d = '0;
                div_err_d = 1'b1;
            end else begin
                sh_int_d  = div_int;
                sh_frac_d = div_frac;
                div_err_d = 1'b0;
            end
        end

        // Active divisor always takes the pre-load shadow, so a load on a boundary lands one period later
        if (sync_clr) begin
            cnt_d      = '0;
            os_cnt_d   = '0;
            acc_d      = '0;
            carry_d    = 1'b0;
            act_int_d  = sh_int_q;
            act_frac_d = sh_frac_q;
        end else if (!en) begin
            act_int_d  = sh_int_q;
            act_frac_d = sh_frac_q;
        end else if (at_end) begin
            cnt_d      = '0;
            os_cnt_d   = os_cnt_nxt;
            {carry_d, acc_d} = frac_sum;
            act_int_d  = sh_int_q;
            act_frac_d = sh_frac_q;
            os_tick_d  = 1'b1;
            mid_tick_d = (os_cnt_q == OS_MID);
            bit_tick_d = (os_cnt_q == OS_LAST);
        end else begin
            cnt_d = cnt_q + (DIV_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_int_q   <= DEF_INT;
            sh_frac_q  <= '0;
            act_int_q  <= DEF_INT;
            act_frac_q <= '0;
            cnt_q      <= '0;
            os_cnt_q   <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            os_tick_q  <= 1'b0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            cnt_q      <= cnt_d;
            os_cnt_q   <= os_cnt_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            os_tick_q  <= os_tick_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
            div_err_q  <= div_err_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign mid_tick = mid_tick_q;
    assign bit_tick = bit_tick_q;
    assign div_err  = div_err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: divisor table with hand-computed period
// lengths, plus sequences for load timing, pause, resync and reset.
module tb_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sync_clr;
    logic        div_load;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        os_tick;
    logic        mid_tick;
    logic        bit_tick;
    logic        div_err;

    int checks   = 0;
    int failures = 0;
    logic prev_os = 1'b0;

    always #5 clk = ~clk;

    baud_gen_frac #(
        .DIV_W  (16),
        .FRAC_W (4),
        .OSR    (16),
        .DEF_DIV(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync_clr(sync_clr),
        .div_load(div_load),
        .div_int (div_int),
        .div_frac(div_frac),
        .os_tick (os_tick),
        .mid_tick(mid_tick),
        .bit_tick(bit_tick),
        .div_err (div_err)
    );

    typedef struct {
        int di;
        int df;
        int err;
        int p1;
        int p2;
        int p3;
        int p4;
        int sum16;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Edges from the current negedge until os_tick is seen at a negedge
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!os_tick && n < 2000);
        if (!os_tick) chk("tick_timeout", int'(os_tick), 1);
    endtask

    task automatic load(input int i, input int f);
        div_load = 1'b1;
        div_int  = 16'(i);
        div_frac = 4'(f);
        @(negedge clk);
        div_load = 1'b0;
    endtask

    task automatic sclr();
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("ticks_back_to_back", int'(prev_os && os_tick), 0);
            chk("sub_tick_without_os", int'((mid_tick || bit_tick) && !os_tick), 0);
        end
        prev_os <= os_tick;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int sum;
        int bit_first;
        int bit_second;
        int mid_at;

        vecs[0] = '{4,  8,  0, 4,  4,  5,  4,  72};
        vecs[1] = '{16, 0,  0, 16, 16, 16, 16, 256};
        vecs[2] = '{2,  0,  0, 2,  2,  2,  2,  32};
        vecs[3] = '{3,  4,  0, 3,  3,  3,  3,  52};
        vecs[4] = '{5,  15, 0, 5,  5,  6,  6,  95};
        vecs[5] = '{7,  1,  0, 7,  7,  7,  7,  113};
        vecs[6] = '{1,  9,  1, 2,  2,  2,  2,  32};
        vecs[7] = '{0,  5,  1, 2,  2,  2,  2,  32};

        rst = 1'b1; en = 1'b0; sync_clr = 1'b0; div_load = 1'b0;
        div_int = '0; div_frac = '0;
        repeat (3) @(negedge clk);
        chk("rst_os_tick", int'(os_tick), 0);
        chk("rst_mid_tick", int'(mid_tick), 0);
        chk("rst_bit_tick", int'(bit_tick), 0);
        chk("rst_div_err", int'(div_err), 0);

        // Defaults: 16-clk oversample period, 256-clk bit
        rst = 1'b0; en = 1'b1;
        k = 0; bit_first = 0; bit_second = 0;
        for (int c = 1; c <= 512; c++) begin
            @(negedge clk);
            if (os_tick) begin
                k++;
                chk("def_os_spacing", c, 16 * k);
                chk("def_mid_pos", int'(mid_tick), int'(k % 16 == 8));
                chk("def_bit_pos", int'(bit_tick), int'(k % 16 == 0));
                if (bit_tick) begin
                    if (bit_first == 0) bit_first = c;
                    else bit_second = c;
                end
            end
        end
        chk("def_os_count", k, 32);
        chk("def_bit_first", bit_first, 256);
        chk("def_bit_period", bit_second - bit_first, 256);

        // Divisor table
        foreach (vecs[r]) begin
            load(vecs[r].di, vecs[r].df);
            chk("tbl_div_err", int'(div_err), vecs[r].err);
            sclr();
            chk("tbl_ticks_after_clr", int'(os_tick || mid_tick || bit_tick), 0);
            wait_tick(n);
            chk("tbl_p1", n, vecs[r].p1);
            sum = 0;
            for (int p = 2; p <= 17; p++) begin
                wait_tick(n);
                if (p == 2) chk("tbl_p2", n, vecs[r].p2);
                if (p == 3) chk("tbl_p3", n, vecs[r].p3);
                if (p == 4) chk("tbl_p4", n, vecs[r].p4);
                sum += n;
            end
            chk("tbl_sum16", sum, vecs[r].sum16);
        end

        // Illegal divisor clamps to 2, legal one clears the error
        load(16, 0);
        sclr();
        wait_tick(n);
        load(1, 0);
        chk("err_set", int'(div_err), 1);
        wait_tick(n);
        chk("err_old_remainder", n, 15);
        wait_tick(n);
        chk("err_clamped_p1", n, 2);
        wait_tick(n);
        chk("err_clamped_p2", n, 2);
        load(6, 0);
        chk("err_cleared", int'(div_err), 0);
        wait_tick(n);
        chk("six_remainder", n, 1);
        wait_tick(n);
        chk("six_p1", n, 6);
        wait_tick(n);
        chk("six_p2", n, 6);

        // Load coincident with a boundary: old length once more, then new
        load(16, 0);
        sclr();
        wait_tick(n);
        repeat (15) @(negedge clk);
        div_load = 1'b1; div_int = 16'd8; div_frac = 4'd0;
        @(negedge clk);
        div_load = 1'b0;
        chk("coincide_tick", int'(os_tick), 1);
        wait_tick(n);
        chk("coincide_next_old", n, 16);
        wait_tick(n);
        chk("coincide_then_new", n, 8);

        // Pause at cnt=5 for 10 cycles with len=8
        repeat (5) @(negedge clk);
        en = 1'b0;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (os_tick || mid_tick || bit_tick) k++;
        end
        chk("pause_no_ticks", k, 0);
        en = 1'b1;
        wait_tick(n);
        chk("pause_resume", n, 3);
        wait_tick(n);
        chk("pause_after", n, 8);

        // Resync with os_cnt=11, mid-period
        sclr();
        for (int t = 0; t < 11; t++) wait_tick(n);
        repeat (3) @(negedge clk);
        sclr();
        chk("resync_ticks_zero", int'(os_tick || mid_tick || bit_tick), 0);
        mid_at = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (mid_tick && mid_at == 0) mid_at = n;
        end while (!bit_tick && n < 400);
        chk("resync_mid_at", mid_at, 64);
        chk("resync_bit_at", n, 128);

        // Async reset while os_tick is high and div_err set
        load(0, 0);
        chk("pre_rst_err", int'(div_err), 1);
        wait_tick(n);
        rst = 1'b1;
        #1;
        chk("rst_async_os", int'(os_tick), 0);
        chk("rst_async_err", int'(div_err), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_tick(n);
        chk("post_rst_p1", n, 16);
        chk("post_rst_mid", int'(mid_tick || bit_tick), 0);

        // Reset mid-period discards the partial period
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_tick(n);
        chk("rst_mid_period", n, 16);
        chk("rst_mid_err", int'(div_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
